// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: oversampled deframer, E0/F0 prefix decoder and FWFT event FIFO.
// Optional macro PS2_ARROW_COUNT_EN adds an arrow-key up/down counter on oKeyCode.
module ps2_keyboard_rx #(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          iCLK,
  input  logic                          iRST_n,
  input  logic                          iPS2_clk,
  input  logic                          iPS2_data,
  output logic                          oEvt_valid,
  input  logic                          iEvt_ready,
  output logic [7:0]                    oEvt_code,
  output logic                          oEvt_ext,
  output logic                          oEvt_break,
  output logic [$clog2(FIFO_DEPTH):0]   oFifo_count,
  output logic                          oFrame_err,
  output logic                          oOverflow
`ifdef PS2_ARROW_COUNT_EN
  ,
  output logic [7:0]                    oKeyCode
`endif
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic [DW-1:0]          tick_cnt;
  logic                   tick, prev_clk, fall;
  logic [3:0]             bit_cnt;
  logic [10:0]            shift;
  logic [TW-1:0]          to_cnt;
  logic                   timeout, frame_ok, push_req, err_now;
  logic                   ext_q, brk_q;
  logic [7:0]             rx_byte;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, wr_en, ovf_now;

  // Pins are resynchronised to idle-high, then sampled only on the divided tick
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      tick_cnt  <= '0;
      tick      <= 1'b0;
      prev_clk  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], iPS2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], iPS2_data};
      tick_cnt  <= (tick_cnt == DIV_MAX) ? '0 : tick_cnt + 1'b1;
      tick      <= (tick_cnt == DIV_MAX);
      if (tick) prev_clk <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall     = tick && prev_clk && !clk_sync[SYNC_STAGES-1];
  assign rx_byte  = shift[8:1];
  assign frame_ok = !shift[0] && shift[10] && (^shift[9:1]);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    timeout    = 1'b0;
    case (state)
      IDLE:  if (fall) next_state = RX;
      RX: begin
        if (fall) begin
          if (bit_cnt == 4'd10) next_state = CHECK;
        end else if (tick && to_cnt == TO_MAX) begin
          next_state = IDLE;
          timeout    = 1'b1;
        end
      end
      CHECK: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign push_req = (state == CHECK) && frame_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
  assign err_now  = ((state == CHECK) && !frame_ok) || timeout;

  // Frames arrive LSB first, so bits enter at the top and walk down to bit 0
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      to_cnt  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall) begin
            shift   <= {data_sync[SYNC_STAGES-1], shift[10:1]};
            bit_cnt <= 4'd1;
          end
        end
        RX: begin
          if (fall) begin
            shift   <= {data_sync[SYNC_STAGES-1], shift[10:1]};
            bit_cnt <= bit_cnt + 1'b1;
            to_cnt  <= '0;
          end else if (timeout) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
          end else if (tick) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          bit_cnt <= '0;
          if (!frame_ok || push_req) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext_q <= 1'b1;
          end else begin
            brk_q <= 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = oEvt_valid && iEvt_ready;
  assign wr_en   = push_req && (!full || pop);
  assign ovf_now = push_req && full && !pop;

  always_ff @(posedge iCLK) begin
    if (wr_en) mem[wr_ptr] <= {ext_q, brk_q, rx_byte};
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      oFrame_err <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      oFrame_err <= err_now;
      oOverflow  <= ovf_now;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign oEvt_valid  = (count != '0);
  assign oFifo_count = count;
  assign oEvt_code   = oEvt_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign oEvt_break  = oEvt_valid ? mem[rd_ptr][8]   : 1'b0;
  assign oEvt_ext    = oEvt_valid ? mem[rd_ptr][9]   : 1'b0;

`ifdef PS2_ARROW_COUNT_EN
  // Counts on every decoded make event, even ones the FIFO drops
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oKeyCode <= 8'h00;
    end else if (push_req && ext_q && !brk_q) begin
      if (rx_byte == 8'h74)      oKeyCode <= oKeyCode + 8'd1;
      else if (rx_byte == 8'h6B) oKeyCode <= oKeyCode - 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: PS/2 frames are driven bit by bit, a byte-level
// decoder model queues expected events and a monitor compares every popped FIFO entry.
module tb_ps2_keyboard_rx;

  localparam int CLK_DIV       = 4;
  localparam int TIMEOUT_TICKS = 50;
  localparam int FIFO_DEPTH    = 8;
  localparam int SYNC_STAGES   = 2;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iPS2_clk = 1'b1;
  logic        iPS2_data = 1'b1;
  logic        iEvt_ready = 1'b0;
  logic        oEvt_valid, oEvt_ext, oEvt_break, oFrame_err, oOverflow;
  logic [7:0]  oEvt_code;
  logic [$clog2(FIFO_DEPTH):0] oFifo_count;
`ifdef PS2_ARROW_COUNT_EN
  logic [7:0]  oKeyCode;
`endif

  ps2_keyboard_rx #(
    .CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iPS2_clk(iPS2_clk), .iPS2_data(iPS2_data),
    .oEvt_valid(oEvt_valid), .iEvt_ready(iEvt_ready), .oEvt_code(oEvt_code),
    .oEvt_ext(oEvt_ext), .oEvt_break(oEvt_break), .oFifo_count(oFifo_count),
    .oFrame_err(oFrame_err), .oOverflow(oOverflow)
`ifdef PS2_ARROW_COUNT_EN
    , .oKeyCode(oKeyCode)
`endif
  );

  always #5 iCLK = ~iCLK;

  int n_compared = 0;
  int n_failed   = 0;
  int err_seen = 0, exp_err = 0;
  int ovf_seen = 0, exp_ovf = 0;
  int rdy_mode = 0;
  logic [9:0] sb [$];
  bit   m_ext = 0, m_brk = 0;
  logic [7:0] m_key = 8'h00;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Byte-level decoder model: prefixes set flags, anything else becomes an event
  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_err++;
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_ext && !m_brk && b == 8'h74) m_key = m_key + 8'd1;
      if (m_ext && !m_brk && b == 8'h6B) m_key = m_key - 8'd1;
      if (sb.size() >= FIFO_DEPTH) exp_ovf++;
      else sb.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Drives nbits of a frame; model is updated right at the stop-bit falling edge
  task automatic applyStimulus(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      iPS2_data = frame[i];
      #100;
      iPS2_clk = 1'b0;
      if (i == 10) model_byte(b, bad);
      #200;
      iPS2_clk = 1'b1;
      #100;
    end
    iPS2_data = 1'b1;
    #400;
  endtask

  task automatic applyReset();
    iRST_n = 1'b0;
    iPS2_clk = 1'b1;
    iPS2_data = 1'b1;
    sb.delete();
    m_ext = 0; m_brk = 0; m_key = 8'h00;
    err_seen = 0; exp_err = 0; ovf_seen = 0; exp_ovf = 0;
    repeat (4) @(negedge iCLK);
    checkOutput("reset valid", oEvt_valid, 0);
    checkOutput("reset code", oEvt_code, 0);
    checkOutput("reset count", oFifo_count, 0);
    checkOutput("reset err", oFrame_err, 0);
    checkOutput("reset ovf", oOverflow, 0);
`ifdef PS2_ARROW_COUNT_EN
    checkOutput("reset keycode", oKeyCode, 0);
`endif
    iRST_n = 1'b1;
    repeat (4) @(negedge iCLK);
  endtask

  task automatic wait_drain(input string name);
    int budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge iCLK);
      budget--;
    end
    repeat (4) @(negedge iCLK);
    checkOutput({name, " queue drained"}, sb.size(), 0);
    checkOutput({name, " dut empty"}, oFifo_count, 0);
  endtask

  always begin
    @(posedge iCLK);
    #2;
    case (rdy_mode)
      0:       iEvt_ready = 1'b0;
      1:       iEvt_ready = 1'b1;
      default: iEvt_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every accepted head entry is compared with the oldest expected event
  always @(negedge iCLK) begin
    if (iRST_n) begin
      if (oFrame_err) err_seen++;
      if (oOverflow)  ovf_seen++;
      if (oEvt_valid && iEvt_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected event", {oEvt_ext, oEvt_break, oEvt_code}, 32'hFFFF);
        end else begin
          checkOutput("event {ext,brk,code}", {oEvt_ext, oEvt_break, oEvt_code}, sb.pop_front());
        end
      end
    end
  end

  initial begin
    applyReset();
    rdy_mode = 1;

    applyStimulus(8'h1C, 0, 11);
    wait_drain("make 1C");

    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'hF0, 0, 11);
    applyStimulus(8'h74, 0, 11);
    wait_drain("E0 F0 74");

    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'h1C, 1, 11);
    applyStimulus(8'h1C, 0, 11);
    wait_drain("parity");
    checkOutput("parity err count", err_seen, exp_err);

    applyStimulus(8'h55, 0, 6);
    #3000;
    exp_err++;
    checkOutput("timeout err count", err_seen, exp_err);
    applyStimulus(8'h32, 0, 11);
    wait_drain("after timeout");

    rdy_mode = 0;
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) applyStimulus(8'(i), 0, 11);
    @(negedge iCLK);
    checkOutput("full count", oFifo_count, FIFO_DEPTH);
    checkOutput("overflow pulses", ovf_seen, exp_ovf);
    checkOutput("head while full", oEvt_code, 8'h01);
    rdy_mode = 1;
    wait_drain("overflow drain");

    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 5))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h74;
        3: b = 8'h6B;
        4: b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(b, $urandom_range(0, 9) == 0, 11);
    end
    rdy_mode = 1;
    wait_drain("random");
    checkOutput("random err count", err_seen, exp_err);
    checkOutput("random ovf count", ovf_seen, exp_ovf);
`ifdef PS2_ARROW_COUNT_EN
    checkOutput("random keycode", oKeyCode, m_key);

    applyReset();
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hE0, 0, 11);
      applyStimulus(8'h74, 0, 11);
    end
    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'h6B, 0, 11);
    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'hF0, 0, 11);
    applyStimulus(8'h74, 0, 11);
    wait_drain("arrows");
    checkOutput("keycode up/down", oKeyCode, m_key);

    applyReset();
    rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hE0, 0, 11);
      applyStimulus(8'h6B, 0, 11);
    end
    wait_drain("arrow wrap");
    checkOutput("keycode wrap", oKeyCode, m_key);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
